// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, register count and the grant encoding used by the write arbiter.
package rf_write_arbiter_pkg;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 3;
  localparam int NUM_REGS         = 2 ** DEF_ADDR_W;
  localparam int DEF_AUX_DEPTH    = 2;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = $clog2(DEF_STARVE_LIMIT + 1);

  // Who owns the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_AUX  = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback, auxiliary and register-file write-port signals.
//
// Aux handshake: a result transfers on a cycle where aux_valid && aux_ready.
// aux_ready depends only on the FIFO being non-full, never on aux_valid, and the
// requester must hold aux_addr/aux_data stable while aux_valid is high and
// aux_ready is low. wb_stall = 1 means the writeback request this cycle is
// ignored and must be presented again.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                   wb_we;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   aux_valid;
  logic                   aux_ready;
  logic [ADDR_W-1:0]      aux_addr;
  logic [DATA_W-1:0]      aux_data;
  logic                   wb_stall;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_addr;
  logic [DATA_W-1:0]      rf_data;
  logic [2**ADDR_W-1:0]   pend_mask;
  // Debug visibility of arbiter state.
  logic [STARVE_W-1:0]    starve_cnt;
  grant_e                 grant;

  modport master (
    output wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    input  aux_ready, wb_stall, rf_we, rf_addr, rf_data, pend_mask,
    input  starve_cnt, grant
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
    output aux_ready, wb_stall, rf_we, rf_addr, rf_data, pend_mask,
    output starve_cnt, grant
  );

endinterface

// File: rtl/rf_aux_fifo.sv
// Small synchronous FIFO holding auxiliary (addr, data) results until granted.
module rf_aux_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_AUX_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] memAddr [DEPTH];
  logic [DATA_W-1:0] memData [DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [PW:0]       wrPtr;
  logic [PW:0]       rdPtr;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign headAddr = memAddr[rdPtr[PW-1:0]];
  assign headData = memData[rdPtr[PW-1:0]];

  // Pointer update; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      memAddr[wrPtr[PW-1:0]] <= pushAddr;
      memData[wrPtr[PW-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and a
// buffered auxiliary requester, with starvation bound and pending scoreboard.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int AUX_DEPTH    = DEF_AUX_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  rf_write_arbiter_if.slave bus
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(AUX_DEPTH + 1);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic              fifoFull;
  logic              fifoEmpty;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              push;
  logic              pop;
  logic              forceAux;
  logic              supersede;
  grant_e            grant;
  logic [STARVE_W-1:0] starveCnt;
  logic [CNT_W-1:0]  pendCnt  [NREG];
  logic [CNT_W-1:0]  pendNext [NREG];
  logic [NREG-1:0]   pendMask;

  rf_aux_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (AUX_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushAddr (bus.aux_addr),
    .pushData (bus.aux_data),
    .pop      (pop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .headAddr (headAddr),
    .headData (headData)
  );

  // No push when full, even if the head pops this cycle.
  assign push = bus.aux_valid && !fifoFull;

  // Grant selection: forced aux, then WB, then aux head, else idle.
  always_comb begin
    grant     = GNT_NONE;
    forceAux  = (starveCnt == LIMIT) && !fifoEmpty;
    if (forceAux)          grant = GNT_AUX;
    else if (bus.wb_we)    grant = GNT_WB;
    else if (!fifoEmpty)   grant = GNT_AUX;
    // A WB write to the head's register makes the older aux data dead.
    supersede = (grant == GNT_WB) && !fifoEmpty && (bus.wb_addr == headAddr);
    pop       = (grant == GNT_AUX) || supersede;
  end

  assign bus.aux_ready  = !fifoFull;
  assign bus.wb_stall   = forceAux;
  assign bus.starve_cnt = starveCnt;
  assign bus.grant      = grant;

  // Starvation counter: counts WB wins while aux waits, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset)                           starveCnt <= '0;
    else if (fifoEmpty || pop)           starveCnt <= '0;
    else if (grant == GNT_WB && starveCnt != LIMIT) starveCnt <= starveCnt + 1'b1;
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rf_we   <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      bus.rf_we <= (grant != GNT_NONE);
      case (grant)
        GNT_WB: begin
          bus.rf_addr <= bus.wb_addr;
          bus.rf_data <= bus.wb_data;
        end
        GNT_AUX: begin
          bus.rf_addr <= headAddr;
          bus.rf_data <= headData;
        end
        default: ;
      endcase
    end
  end

  // Next pending count per register: +1 on push, -1 on pop/discard.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pendNext[r] = pendCnt[r];
      if ((push && bus.aux_addr == ADDR_W'(r)) && !(pop && headAddr == ADDR_W'(r)))
        pendNext[r] = pendCnt[r] + 1'b1;
      else if (!(push && bus.aux_addr == ADDR_W'(r)) && (pop && headAddr == ADDR_W'(r)))
        pendNext[r] = pendCnt[r] - 1'b1;
    end
  end

  // Pending counter registers.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) pendCnt[r] <= '0;
      else       pendCnt[r] <= pendNext[r];
    end
  end

  // Decode-visible mask: register has at least one queued aux write.
  always_comb begin
    for (int r = 0; r < NREG; r++) pendMask[r] = (pendCnt[r] != '0);
  end

  assign bus.pend_mask = pendMask;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with an expected-write scoreboard.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int W = DEF_ADDR_W + DEF_DATA_W;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [DEF_ADDR_W-1:0] a, input logic [DEF_DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drive_wb(input logic we, input logic [DEF_ADDR_W-1:0] a, input logic [DEF_DATA_W-1:0] d);
    bus.wb_we   = we;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic drive_aux(input logic v, input logic [DEF_ADDR_W-1:0] a, input logic [DEF_DATA_W-1:0] d);
    bus.aux_valid = v;
    bus.aux_addr  = a;
    bus.aux_data  = d;
  endtask

  // Scoreboard: every rf write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write observed=%0h:%0h expected=none", bus.rf_addr, bus.rf_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        assert ({bus.rf_addr, bus.rf_data} === e) else begin
          errors++;
          $error("FAIL rf_write observed=%0h expected=%0h", {bus.rf_addr, bus.rf_data}, e);
        end
      end
    end
  end

  initial begin
    logic [DEF_DATA_W-1:0] d;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_wb(1'b0, '0, '0);
    drive_aux(1'b0, '0, '0);

    // 1. Reset dominates same-cycle requests.
    drive_wb(1'b1, 3'd5, 16'hAAAA);
    drive_aux(1'b1, 3'd7, 16'h7777);
    cyc();
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
    check("rst_rf_data", 32'(bus.rf_data), 32'd0);
    check("rst_pend", 32'(bus.pend_mask), 32'd0);
    check("rst_aux_ready", 32'(bus.aux_ready), 32'd1);
    check("rst_wb_stall", 32'(bus.wb_stall), 32'd0);
    reset = 1'b0;
    drive_aux(1'b0, '0, '0);
    expect_write(3'd5, 16'hAAAA);
    cyc();
    check("post_rst_we", 32'(bus.rf_we), 32'd1);
    drive_wb(1'b0, '0, '0);
    cyc();

    // 2. Aux only: push, then granted next cycle, visible one cycle later.
    drive_aux(1'b1, 3'd3, 16'hBBBB);
    expect_write(3'd3, 16'hBBBB);
    cyc();
    check("aux_pend_set", 32'(bus.pend_mask), 32'h08);
    check("aux_no_bypass", 32'(bus.rf_we), 32'd0);
    drive_aux(1'b0, '0, '0);
    cyc();
    check("aux_written", 32'(bus.rf_we), 32'd1);
    check("aux_pend_clr", 32'(bus.pend_mask), 32'd0);
    cyc();

    // 3. Fill the FIFO while WB writes addr 1 every cycle.
    drive_wb(1'b1, 3'd1, 16'h1001); drive_aux(1'b1, 3'd2, 16'h2002);
    expect_write(3'd1, 16'h1001);
    cyc();
    check("full_starve_empty", 32'(bus.starve_cnt), 32'd0);
    drive_wb(1'b1, 3'd1, 16'h1002); drive_aux(1'b1, 3'd3, 16'h3003);
    expect_write(3'd1, 16'h1002);
    cyc();
    check("full_ready", 32'(bus.aux_ready), 32'd0);
    check("full_pend", 32'(bus.pend_mask), 32'h0C);
    drive_wb(1'b1, 3'd1, 16'h1003); drive_aux(1'b1, 3'd5, 16'h5005);
    expect_write(3'd1, 16'h1003);
    cyc();
    check("full_reject", 32'(bus.pend_mask), 32'h0C);
    drive_aux(1'b0, '0, '0);
    drive_wb(1'b1, 3'd1, 16'h1004); expect_write(3'd1, 16'h1004);
    cyc();
    drive_wb(1'b1, 3'd1, 16'h1005); expect_write(3'd1, 16'h1005);
    cyc();
    check("full_starve_lim", 32'(bus.starve_cnt), 32'd4);
    check("full_stall", 32'(bus.wb_stall), 32'd1);
    drive_wb(1'b1, 3'd1, 16'h1006); expect_write(3'd2, 16'h2002);
    cyc();
    check("full_forced_stall_clr", 32'(bus.wb_stall), 32'd0);
    check("full_forced_starve", 32'(bus.starve_cnt), 32'd0);
    check("full_forced_pend", 32'(bus.pend_mask), 32'h08);
    check("full_ready_back", 32'(bus.aux_ready), 32'd1);
    expect_write(3'd1, 16'h1006);
    cyc();
    drive_wb(1'b0, '0, '0); expect_write(3'd3, 16'h3003);
    cyc();
    check("full_drained_pend", 32'(bus.pend_mask), 32'd0);
    cyc();

    // 4. Starvation with one queued entry and WB to addr 2 every cycle.
    drive_aux(1'b1, 3'd6, 16'hCCCC);
    cyc();
    drive_aux(1'b0, '0, '0);
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      drive_wb(1'b1, 3'd2, d);
      expect_write(3'd2, d);
      cyc();
      check("starve_cnt", 32'(bus.starve_cnt), 32'(i + 1));
      check("starve_stall", 32'(bus.wb_stall), (i == 3) ? 32'd1 : 32'd0);
    end
    expect_write(3'd6, 16'hCCCC);
    cyc();
    check("starve_cleared", 32'(bus.starve_cnt), 32'd0);
    check("starve_stall_off", 32'(bus.wb_stall), 32'd0);
    check("starve_pend", 32'(bus.pend_mask), 32'd0);
    expect_write(3'd2, d);
    cyc();
    drive_wb(1'b0, '0, '0);
    cyc();

    // 5. Supersede: WB to the head's register drops the older aux data.
    drive_aux(1'b1, 3'd4, 16'h1111);
    cyc();
    check("sup_pend_set", 32'(bus.pend_mask), 32'h10);
    drive_aux(1'b0, '0, '0);
    drive_wb(1'b1, 3'd4, 16'h2222);
    expect_write(3'd4, 16'h2222);
    cyc();
    check("sup_pend_clr", 32'(bus.pend_mask), 32'd0);
    check("sup_empty", 32'(bus.aux_ready), 32'd1);
    drive_wb(1'b0, '0, '0);
    cyc();
    check("sup_no_old_write", 32'(bus.rf_we), 32'd0);
    cyc();
    check("sup_still_idle", 32'(bus.rf_we), 32'd0);

    // 6. Reset with two queued entries discards them.
    drive_wb(1'b1, 3'd0, 16'h0001); drive_aux(1'b1, 3'd1, 16'hAAA1);
    expect_write(3'd0, 16'h0001);
    cyc();
    drive_wb(1'b1, 3'd0, 16'h0002); drive_aux(1'b1, 3'd2, 16'hAAA2);
    expect_write(3'd0, 16'h0002);
    cyc();
    check("mid_pend", 32'(bus.pend_mask), 32'h06);
    check("mid_full", 32'(bus.aux_ready), 32'd0);
    reset = 1'b1;
    drive_wb(1'b0, '0, '0); drive_aux(1'b0, '0, '0);
    cyc();
    check("mid_rst_we", 32'(bus.rf_we), 32'd0);
    check("mid_rst_pend", 32'(bus.pend_mask), 32'd0);
    check("mid_rst_ready", 32'(bus.aux_ready), 32'd1);
    reset = 1'b0;
    cyc();
    check("mid_dropped_1", 32'(bus.rf_we), 32'd0);
    cyc();
    check("mid_dropped_2", 32'(bus.rf_we), 32'd0);
    cyc();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
